region_rmw_sequencer: RTL and testbench

Parametrised Avalon-MM master that sweeps a 2-D grid of fixed-size regions stored in SDRAM. For each region it burst-reads WORDS_X*WORDS_Y words with pipelined reads and hands the region to an external update unit through a start/done handshake. It then writes back only the words that changed and advances to the next region origin. It replaces the fixed 4-word, fixed-timing read/update/write loop in the sand top level, and sits between the physics update logic and the SDRAM master port.

---
 rtl/region_rmw_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_region_rmw_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/region_rmw_sequencer.sv
// Avalon-MM read/update/write sequencer sweeping a 2-D grid of regions.
// Reads a region with pipelined reads, hands it off, writes back dirty words.
module region_rmw_sequencer #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 24,
    parameter int WORDS_X    = 2,
    parameter int WORDS_Y    = 2,
    parameter int ROW_STRIDE = 80,
    parameter int SWEEP_COLS = 79,
    parameter int SWEEP_ROWS = 479,
    parameter int STEP_X     = 1,
    parameter int STEP_Y     = 1,
    parameter int SKIP_CLEAN = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    output logic [ADDR_W-1:0]             mem_address,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [DATA_W-1:0]             mem_writedata,
    input  logic                          mem_waitrequest,
    input  logic                          mem_readdatavalid,
    input  logic [DATA_W-1:0]             mem_readdata,
    output logic [WORDS_X*WORDS_Y*DATA_W-1:0] region_data,
    input  logic [WORDS_X*WORDS_Y*DATA_W-1:0] new_region_data,
    output logic                          upd_start,
    input  logic                          upd_done,
    output logic [ADDR_W-1:0]             region_origin,
    output logic                          busy,
    output logic                          frame_done
);
    localparam int N  = WORDS_X * WORDS_Y;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);
    localparam int XW = (SWEEP_COLS > 1) ? $clog2(SWEEP_COLS) : 1;
    localparam int YW = (SWEEP_ROWS > 1) ? $clog2(SWEEP_ROWS) : 1;
    localparam logic [XW-1:0] COL_LAST = XW'(SWEEP_COLS - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(SWEEP_ROWS - 1);
    localparam logic [CW-1:0] N_CNT    = CW'(N);
    localparam logic [IW-1:0] K_LAST   = IW'(N - 1);

    typedef enum logic [2:0] {
        IDLE, READ, DRAIN, UPDATE, WRITE, ADVANCE
    } state_t;

    state_t              state;
    logic [IW-1:0]       issue_cnt;
    logic [IW-1:0]       wr_idx;
    logic [CW-1:0]       rx_cnt;
    logic [XW-1:0]       col;
    logic [YW-1:0]       row;
    logic [ADDR_W-1:0]   row_base;
    logic [N*DATA_W-1:0] wbuf;
    logic [N-1:0]        mask;

    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [ADDR_W-1:0] org,
        input int                k
    );
        return org + ADDR_W'((k / WORDS_X) * ROW_STRIDE + (k % WORDS_X));
    endfunction

    // {found, index} of the lowest set mask bit at or above from
    function automatic logic [IW:0] next_set(
        input logic [N-1:0] m,
        input int           from
    );
        logic [IW:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--)
            if (i >= from && m[i])
                r = {1'b1, IW'(i)};
        return r;
    endfunction

    logic [N-1:0]      mask_new;
    logic [IW:0]       first_w;
    logic [IW:0]       next_w;
    logic [ADDR_W-1:0] nxt_origin;
    logic [ADDR_W-1:0] nxt_base;
    logic [XW-1:0]     nxt_col;
    logic [YW-1:0]     nxt_row;
    logic              wrap;

    always_comb begin
        mask_new = '0;
        for (int k = 0; k < N; k++)
            mask_new[k] = (SKIP_CLEAN == 0) ||
                (new_region_data[k*DATA_W +: DATA_W] !=
                 region_data[k*DATA_W +: DATA_W]);
        first_w = next_set(mask_new, 0);
        next_w  = next_set(mask, int'(wr_idx) + 1);
    end

    always_comb begin
        nxt_col    = col + 1'b1;
        nxt_row    = row;
        nxt_base   = row_base;
        nxt_origin = region_origin + ADDR_W'(STEP_X);
        wrap       = 1'b0;
        if (col == COL_LAST) begin
            nxt_col = '0;
            if (row != ROW_LAST) begin
                nxt_row    = row + 1'b1;
                nxt_base   = row_base + ADDR_W'(STEP_Y * ROW_STRIDE);
                nxt_origin = nxt_base;
            end else begin
                nxt_row    = '0;
                nxt_base   = '0;
                nxt_origin = '0;
                wrap       = 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            issue_cnt     <= '0;
            wr_idx        <= '0;
            rx_cnt        <= '0;
            col           <= '0;
            row           <= '0;
            row_base      <= '0;
            wbuf          <= '0;
            mask          <= '0;
            mem_address   <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_writedata <= '0;
            region_data   <= '0;
            region_origin <= '0;
            upd_start     <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            upd_start  <= 1'b0;
            frame_done <= 1'b0;
            // read data may trail the last request, so capture in READ and DRAIN
            if ((state == READ || state == DRAIN) &&
                mem_readdatavalid && rx_cnt != N_CNT) begin
                region_data[int'(rx_cnt)*DATA_W +: DATA_W] <= mem_readdata;
                rx_cnt <= rx_cnt + 1'b1;
            end
            unique case (state)
                IDLE: if (enable) begin
                    state       <= READ;
                    mem_read    <= 1'b1;
                    mem_address <= region_origin;
                    issue_cnt   <= '0;
                    rx_cnt      <= '0;
                end
                READ: if (!mem_waitrequest) begin
                    if (issue_cnt == K_LAST) begin
                        mem_read <= 1'b0;
                        state    <= DRAIN;
                    end else begin
                        issue_cnt   <= issue_cnt + 1'b1;
                        mem_address <= word_addr(region_origin,
                                                 int'(issue_cnt) + 1);
                    end
                end
                DRAIN: if (rx_cnt == N_CNT ||
                           (mem_readdatavalid && rx_cnt == N_CNT - 1'b1)) begin
                    state     <= UPDATE;
                    upd_start <= 1'b1;
                end
                UPDATE: if (upd_done) begin
                    wbuf  <= new_region_data;
                    mask  <= mask_new;
                    state <= WRITE;
                    if (first_w[IW]) begin
                        mem_write     <= 1'b1;
                        wr_idx        <= first_w[IW-1:0];
                        mem_address   <= word_addr(region_origin,
                                                   int'(first_w[IW-1:0]));
                        mem_writedata <= new_region_data[
                            int'(first_w[IW-1:0])*DATA_W +: DATA_W];
                    end
                end
                WRITE: if (!mem_write) begin
                    state      <= ADVANCE;
                    frame_done <= wrap;
                end else if (!mem_waitrequest) begin
                    if (next_w[IW]) begin
                        wr_idx        <= next_w[IW-1:0];
                        mem_address   <= word_addr(region_origin,
                                                   int'(next_w[IW-1:0]));
                        mem_writedata <= wbuf[
                            int'(next_w[IW-1:0])*DATA_W +: DATA_W];
                    end else begin
                        mem_write  <= 1'b0;
                        state      <= ADVANCE;
                        frame_done <= wrap;
                    end
                end
                ADVANCE: begin
                    col           <= nxt_col;
                    row           <= nxt_row;
                    row_base      <= nxt_base;
                    region_origin <= nxt_origin;
                    if (enable) begin
                        state       <= READ;
                        mem_read    <= 1'b1;
                        mem_address <= nxt_origin;
                        issue_cnt   <= '0;
                        rx_cnt      <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_region_rmw_sequencer.sv
// Scoreboard bench for region_rmw_sequencer on a 2x2 sweep grid.
// Slave returns memory[a]=a; update unit adds 1 to selected words.
module tb_region_rmw_sequencer;
    localparam int DW = 16;
    localparam int AW = 24;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_writedata;
    logic          mem_waitrequest = 1'b0;
    logic          mem_readdatavalid = 1'b0;
    logic [DW-1:0] mem_readdata = '0;
    logic [63:0]   region_data;
    logic [63:0]   new_region_data;
    logic          upd_start;
    logic          upd_done = 1'b0;
    logic [AW-1:0] region_origin;
    logic          busy;
    logic          frame_done;

    region_rmw_sequencer #(
        .SWEEP_COLS(2),
        .SWEEP_ROWS(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .mem_address(mem_address),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_writedata(mem_writedata),
        .mem_waitrequest(mem_waitrequest),
        .mem_readdatavalid(mem_readdatavalid),
        .mem_readdata(mem_readdata),
        .region_data(region_data),
        .new_region_data(new_region_data),
        .upd_start(upd_start),
        .upd_done(upd_done),
        .region_origin(region_origin),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } rd_t;

    rd_t           pend[$];
    logic [AW-1:0] exp_rd[$];
    logic [39:0]   exp_wr[$];
    logic [63:0]   exp_reg[$];
    logic [AW-1:0] exp_fd[$];

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int rd_lat = 1;
    int rd_acc = 0;
    int rd_stall_at = -1;
    int rd_stall_left = 0;
    int rd_stall_cnt = 0;
    bit wr_stall = 0;
    int mode = 0;
    int done_delay = 0;
    bit pend_done = 0;
    int dcnt = 0;
    int upd_cnt = 0;
    int fd_cnt = 0;
    bit stalled_prev = 0;
    logic [AW-1:0] held_addr = '0;

    function automatic void chk(string nm, logic [63:0] act,
                                logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endfunction

    function automatic void tmo(string nm);
        checks++;
        fails++;
        $display("FAIL %s: timeout", nm);
    endfunction

    function automatic logic [AW-1:0] wa(int o, int k);
        return AW'(o + (k / 2) * 80 + k % 2);
    endfunction

    // update unit: mode 0 adds 1 to all words, 1 to word1 only, 2 identity
    always_comb begin
        new_region_data = region_data;
        for (int k = 0; k < 4; k++)
            if (mode == 0 || (mode == 1 && k == 1))
                new_region_data[k*16 +: 16] = region_data[k*16 +: 16] + 16'd1;
    end

    // slave model, update-unit handshake and scoreboard monitor
    always @(negedge clock) begin
        if (reset) begin
            pend.delete();
            mem_readdatavalid = 1'b0;
            mem_waitrequest = 1'b0;
            upd_done = 1'b0;
            pend_done = 0;
            stalled_prev = 0;
        end else begin
            mem_readdatavalid = 1'b0;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_readdatavalid = 1'b1;
                mem_readdata = pend[0].d;
                pend.delete(0);
            end
            mem_waitrequest = 1'b0;
            if (mem_read && rd_acc == rd_stall_at && rd_stall_left > 0) begin
                mem_waitrequest = 1'b1;
                rd_stall_left--;
                rd_stall_cnt++;
            end
            if (mem_write && wr_stall)
                mem_waitrequest = 1'b1;
            upd_done = 1'b0;
            if (upd_start) begin
                pend_done = 1;
                dcnt = done_delay;
            end
            if (pend_done) begin
                if (dcnt == 0) begin
                    upd_done = 1'b1;
                    pend_done = 0;
                end else begin
                    dcnt--;
                end
            end
            if (mem_read && mem_write)
                chk("rw_exclusive", {mem_read, mem_write}, 64'd2);
            if (stalled_prev && mem_read)
                chk("rd_hold", mem_address, held_addr);
            stalled_prev = mem_read && mem_waitrequest;
            held_addr = mem_address;
            if (mem_read && !mem_waitrequest) begin
                pend.push_back(rd_t'{mem_address[DW-1:0], cyc + rd_lat});
                rd_acc++;
                if (exp_rd.size() == 0)
                    chk("rd_unexpected", mem_address, 64'hFFFF_FFFF);
                else
                    chk("rd_addr", mem_address, exp_rd.pop_front());
            end
            if (mem_write && !mem_waitrequest) begin
                if (exp_wr.size() == 0)
                    chk("wr_unexpected", {mem_address, mem_writedata},
                        64'hFFFF_FFFF_FFFF);
                else
                    chk("wr_addr_data", {mem_address, mem_writedata},
                        exp_wr.pop_front());
            end
            if (upd_start) begin
                upd_cnt++;
                if (exp_reg.size() == 0)
                    chk("region_unexpected", region_data, ~64'd0);
                else
                    chk("region_data", region_data, exp_reg.pop_front());
            end
            if (frame_done) begin
                fd_cnt++;
                if (exp_fd.size() == 0)
                    chk("fd_unexpected", region_origin, 64'hFFFF_FFFF);
                else
                    chk("fd_origin", region_origin, exp_fd.pop_front());
            end
        end
        cyc++;
    end

    task automatic push_region(input int o, input int md);
        logic [AW-1:0] a;
        logic [63:0]   r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            a = wa(o, k);
            exp_rd.push_back(a);
            r[k*16 +: 16] = a[15:0];
            if (md == 0 || (md == 1 && k == 1))
                exp_wr.push_back({a, a[15:0] + 16'd1});
        end
        exp_reg.push_back(r);
    endtask

    task automatic wait_upd(input string nm);
        int n = 0;
        while (!upd_start && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!upd_start) tmo(nm);
    endtask

    task automatic run_region(input int o, input int nexto, input int md,
                              input int dly, input bit fd);
        int n = 0;
        mode = md;
        done_delay = dly;
        push_region(o, md);
        if (fd) exp_fd.push_back(AW'(o));
        enable = 1'b1;
        wait_upd("upd_wait");
        enable = 1'b0;
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (busy) tmo("idle_wait");
        chk("origin_next", region_origin, 64'(nexto));
    endtask

    initial begin
        int n;
        #12;
        chk("rst_strobes", {mem_read, mem_write, upd_start, frame_done},
            64'd0);
        chk("rst_busy", busy, 64'd0);
        chk("rst_origin", region_origin, 64'd0);
        chk("rst_region", region_data, 64'd0);
        chk("rst_addr", mem_address, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_busy", busy, 64'd0);

        run_region(0, 1, 0, 0, 0);
        chk("region0_hold", region_data, 64'h0051_0050_0001_0000);

        rd_lat = 6;
        rd_stall_at = rd_acc + 1;
        rd_stall_left = 3;
        rd_stall_cnt = 0;
        run_region(1, 80, 1, 0, 0);
        chk("rd_stall_cycles", rd_stall_cnt, 64'd3);
        chk("region1_hold", region_data, 64'h0052_0051_0002_0001);

        rd_lat = 1;
        run_region(80, 81, 2, 3, 0);
        chk("busy_after_drop", busy, 64'd0);
        chk("fd_before_wrap", fd_cnt, 64'd0);

        run_region(81, 0, 0, 0, 1);
        chk("fd_count", fd_cnt, 64'd1);

        // reset while a write is stalled; no writes are accepted
        mode = 0;
        done_delay = 0;
        wr_stall = 1;
        for (int k = 0; k < 4; k++) exp_rd.push_back(wa(0, k));
        exp_reg.push_back(64'h0051_0050_0001_0000);
        enable = 1'b1;
        wait_upd("upd_wait_rst");
        enable = 1'b0;
        n = 0;
        while (!mem_write && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!mem_write) tmo("wr_wait");
        repeat (2) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_wr", mem_write, 64'd0);
        chk("rst_async_busy", busy, 64'd0);
        @(negedge clock);
        #1;
        wr_stall = 0;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_origin2", region_origin, 64'd0);
        chk("rst_region2", region_data, 64'd0);

        run_region(0, 1, 0, 0, 0);

        chk("exp_rd_empty", exp_rd.size(), 64'd0);
        chk("exp_wr_empty", exp_wr.size(), 64'd0);
        chk("exp_reg_empty", exp_reg.size(), 64'd0);
        chk("exp_fd_empty", exp_fd.size(), 64'd0);
        chk("upd_pulses", upd_cnt, 64'd6);
        chk("fd_final", fd_cnt, 64'd1);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
